// File: rtl/branch_resolve_unit_pkg.sv
// ----------------------------------------------------------------------------
// branch_resolve_unit_pkg
//   Shared definitions for the branch resolution unit and its in-flight
//   prediction queue.
//   - br_fsm_e          : resolution FSM encodings (RUN / FLUSH)
//   - DELAY_SLOT_OFFSET : fall-through distance of a branch (branch + delay slot)
//   - br_entry_t        : one in-flight prediction {addr, pred_taken}
// ----------------------------------------------------------------------------
package branch_resolve_unit_pkg;

    localparam int          ADDR_W            = 32;
    localparam logic [31:0] DELAY_SLOT_OFFSET = 32'd8;

    typedef enum logic {
        BR_FSM_RUN   = 1'b0,
        BR_FSM_FLUSH = 1'b1
    } br_fsm_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              pred_taken;
    } br_entry_t;

endpackage

// File: rtl/branch_resolve_unit_queue.sv
// ----------------------------------------------------------------------------
// branch_queue
//   In-order FIFO of in-flight branch predictions.
//   Ports:
//     clk_i, rst_ni : clock, asynchronous active-low reset
//     push_i        : write wdata_i at the tail (ignored when full)
//     pop_i         : drop the head entry (ignored when empty)
//     clear_i       : reset both pointers; wins over push/pop
//     wdata_i       : entry to enqueue
//     full_o        : no free slot
//     empty_o       : no valid entry
//     head_o        : oldest entry (meaningless when empty)
//   Pointers carry one extra wrap bit: equal low bits with different wrap
//   bits means full, fully equal pointers means empty.
// ----------------------------------------------------------------------------
module branch_queue
    import branch_resolve_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      push_i,
    input  logic      pop_i,
    input  logic      clear_i,
    input  br_entry_t wdata_i,
    output logic      full_o,
    output logic      empty_o,
    output br_entry_t head_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
    br_entry_t      mem_q [DEPTH];
    logic           do_push;
    logic           do_pop;

    assign full_o  = (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]) &&
                     (wr_ptr_q[PTR_W]     != rd_ptr_q[PTR_W]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign head_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

    assign do_push = push_i && !full_o && !clear_i;
    assign do_pop  = pop_i && !empty_o && !clear_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// ----------------------------------------------------------------------------
// branch_resolve_unit
//   Resolution end of the branch predictor. Keeps in-flight predictions in
//   order, compares the oldest with the execute-stage outcome, trains the
//   predictor and raises mispredict/redirect towards fetch.
//   Ports:
//     CLK, RESET           : clock, asynchronous active-low reset
//     Pred_valid/addr/taken: fetch enqueues a predicted branch
//     Pred_ready           : queue accepts (not full and FSM in RUN)
//     Resolve_valid/taken/target : execute resolves the oldest branch
//     Branch_resolved(_addr): registered training pair, addr 0 = no update
//     Mispredict, Redirect_addr : one-cycle pulse and correct next fetch PC
//     Resolve_error        : one-cycle pulse, resolve arrived with empty queue
//     Branch_count, Mispredict_count : wrapping statistics
//     Fsm_state            : current FSM state, for observation
//   Valid/ready: an enqueue happens on a cycle where Pred_valid and
//   Pred_ready are both high; Pred_valid while Pred_ready is low is dropped,
//   not held. Resolve_valid has no back-pressure.
// ----------------------------------------------------------------------------
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              Pred_valid,
    input  logic [31:0]       Pred_addr,
    input  logic              Pred_taken,
    output logic              Pred_ready,
    input  logic              Resolve_valid,
    input  logic              Resolve_taken,
    input  logic [31:0]       Resolve_target,
    output logic              Branch_resolved,
    output logic [31:0]       Branch_resolved_addr,
    output logic              Mispredict,
    output logic [31:0]       Redirect_addr,
    output logic              Resolve_error,
    output logic [CNT_W-1:0]  Branch_count,
    output logic [CNT_W-1:0]  Mispredict_count,
    output br_fsm_e           Fsm_state
);

    br_fsm_e          state_q, state_d;
    logic             resolved_q, resolved_d;
    logic [31:0]      resolved_addr_q, resolved_addr_d;
    logic             mispredict_q, mispredict_d;
    logic [31:0]      redirect_q, redirect_d;
    logic             error_q, error_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] mp_cnt_q, mp_cnt_d;

    logic      q_full;
    logic      q_empty;
    br_entry_t q_head;
    br_entry_t q_wdata;
    logic      q_push;
    logic      q_pop;
    logic      q_clear;
    logic      in_run;
    logic      resolve_fire;
    logic      wrong;

    assign in_run       = (state_q == BR_FSM_RUN);
    assign Pred_ready   = !q_full && in_run;
    assign resolve_fire = Resolve_valid && in_run && !q_empty;
    assign wrong        = resolve_fire && (q_head.pred_taken != Resolve_taken);

    // An enqueue in the same cycle as a mispredicting resolve is on the
    // wrong path and is discarded.
    assign q_push        = Pred_valid && Pred_ready && !wrong;
    assign q_pop         = resolve_fire;
    assign q_clear       = (state_q == BR_FSM_FLUSH);
    assign q_wdata.addr       = Pred_addr;
    assign q_wdata.pred_taken = Pred_taken;

    branch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk_i   (CLK),
        .rst_ni  (RESET),
        .push_i  (q_push),
        .pop_i   (q_pop),
        .clear_i (q_clear),
        .wdata_i (q_wdata),
        .full_o  (q_full),
        .empty_o (q_empty),
        .head_o  (q_head)
    );

    always_comb begin
        state_d         = state_q;
        resolved_d      = 1'b0;
        resolved_addr_d = '0;
        mispredict_d    = 1'b0;
        redirect_d      = '0;
        error_d         = 1'b0;
        br_cnt_d        = br_cnt_q;
        mp_cnt_d        = mp_cnt_q;

        unique case (state_q)
            BR_FSM_RUN: begin
                if (resolve_fire) begin
                    resolved_d      = Resolve_taken;
                    resolved_addr_d = q_head.addr;
                    br_cnt_d        = br_cnt_q + 1'b1;
                    if (wrong) begin
                        mispredict_d = 1'b1;
                        mp_cnt_d     = mp_cnt_q + 1'b1;
                        redirect_d   = Resolve_taken ? Resolve_target
                                                     : q_head.addr + DELAY_SLOT_OFFSET;
                        state_d      = BR_FSM_FLUSH;
                    end
                end else if (Resolve_valid) begin
                    error_d = 1'b1;
                end
            end
            // One cycle to drop every younger (wrong-path) entry.
            BR_FSM_FLUSH: begin
                state_d = BR_FSM_RUN;
            end
            default: begin
                state_d = BR_FSM_RUN;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q         <= BR_FSM_RUN;
            resolved_q      <= 1'b0;
            resolved_addr_q <= '0;
            mispredict_q    <= 1'b0;
            redirect_q      <= '0;
            error_q         <= 1'b0;
            br_cnt_q        <= '0;
            mp_cnt_q        <= '0;
        end else begin
            state_q         <= state_d;
            resolved_q      <= resolved_d;
            resolved_addr_q <= resolved_addr_d;
            mispredict_q    <= mispredict_d;
            redirect_q      <= redirect_d;
            error_q         <= error_d;
            br_cnt_q        <= br_cnt_d;
            mp_cnt_q        <= mp_cnt_d;
        end
    end

    assign Branch_resolved      = resolved_q;
    assign Branch_resolved_addr = resolved_addr_q;
    assign Mispredict           = mispredict_q;
    assign Redirect_addr        = redirect_q;
    assign Resolve_error        = error_q;
    assign Branch_count         = br_cnt_q;
    assign Mispredict_count     = mp_cnt_q;
    assign Fsm_state            = state_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;
  import branch_resolve_unit_pkg::*;

  localparam int DEPTH = 4;
  localparam int W     = 66;  // {addr, resolved, mispredict, redirect}

  // ---------------- clock / reset ----------------
  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  always #5 CLK = ~CLK;

  logic        Pred_valid = 1'b0;
  logic [31:0] Pred_addr = '0;
  logic        Pred_taken = 1'b0;
  logic        Pred_ready;
  logic        Resolve_valid = 1'b0;
  logic        Resolve_taken = 1'b0;
  logic [31:0] Resolve_target = '0;
  logic        Branch_resolved;
  logic [31:0] Branch_resolved_addr;
  logic        Mispredict;
  logic [31:0] Redirect_addr;
  logic        Resolve_error;
  logic [31:0] Branch_count;
  logic [31:0] Mispredict_count;
  br_fsm_e     Fsm_state;

  branch_resolve_unit #(.DEPTH(DEPTH), .CNT_W(32)) dut (
    .CLK                  (CLK),
    .RESET                (RESET),
    .Pred_valid           (Pred_valid),
    .Pred_addr            (Pred_addr),
    .Pred_taken           (Pred_taken),
    .Pred_ready           (Pred_ready),
    .Resolve_valid        (Resolve_valid),
    .Resolve_taken        (Resolve_taken),
    .Resolve_target       (Resolve_target),
    .Branch_resolved      (Branch_resolved),
    .Branch_resolved_addr (Branch_resolved_addr),
    .Mispredict           (Mispredict),
    .Redirect_addr        (Redirect_addr),
    .Resolve_error        (Resolve_error),
    .Branch_count         (Branch_count),
    .Mispredict_count     (Mispredict_count),
    .Fsm_state            (Fsm_state)
  );

  int checks = 0;
  int failures = 0;

  // ---------------- scoreboard / reference model ----------------
  logic [W-1:0]  exp_q[$];
  logic [32:0]   m_q[$];     // {addr, pred_taken}
  bit            m_flush = 1'b0;
  int unsigned   m_bcount = 0;
  int unsigned   m_mcount = 0;
  bit            exp_err = 1'b0;
  bit            exp_ready = 1'b1;

  task automatic model_reset();
    m_q.delete();
    exp_q.delete();
    m_flush = 1'b0;
    m_bcount = 0;
    m_mcount = 0;
    exp_err = 1'b0;
    exp_ready = 1'b1;
  endtask

  // Drives one cycle of stimulus starting #1 after a rising edge, advances
  // the reference model, and returns #1 after the next rising edge.
  task automatic drive_cycle(input logic pv, input logic [31:0] pa, input logic pt,
                             input logic rv, input logic rt, input logic [31:0] rtgt);
    logic [32:0] h;
    bit          run, ready, fire, misp;
    logic [31:0] redir;
    Pred_valid = pv; Pred_addr = pa; Pred_taken = pt;
    Resolve_valid = rv; Resolve_taken = rt; Resolve_target = rtgt;
    run   = !m_flush;
    ready = run && (m_q.size() < DEPTH);
    fire  = rv && run && (m_q.size() > 0);
    misp  = 1'b0;
    exp_err = rv && run && (m_q.size() == 0);
    if (fire) begin
      h = m_q.pop_front();
      misp = (h[0] != rt);
      redir = rt ? rtgt : h[32:1] + 32'd8;
      exp_q.push_back({h[32:1], rt, misp, misp ? redir : 32'h0});
      m_bcount++;
      if (misp) m_mcount++;
    end
    if (pv && ready && !misp) m_q.push_back({pa, pt});
    if (m_flush) begin
      m_q.delete();
      m_flush = 1'b0;
    end else begin
      m_flush = misp;
    end
    exp_ready = !m_flush && (m_q.size() < DEPTH);
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    drive_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  // Monitor: every training output is matched against the expected queue.
  always @(negedge CLK) begin
    if (RESET) begin
      if (Branch_resolved_addr != 32'h0) begin
        logic [W-1:0] got, exp;
        got = {Branch_resolved_addr, Branch_resolved, Mispredict,
               Mispredict ? Redirect_addr : 32'h0};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output got=%h expected=none", got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            failures++;
            $display("FAIL training_output got=%h expected=%h", got, exp);
          end
        end
      end else begin
        checks++;
        if ({Branch_resolved, Mispredict} !== 2'b00) begin
          failures++;
          $display("FAIL idle_outputs got br=%b misp=%b expected 0 0", Branch_resolved, Mispredict);
        end
      end
    end
  end

  task automatic apply_reset();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d pending expected=0", exp_q.size());
    end
    Pred_valid = 0; Resolve_valid = 0;
    RESET = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    drive_cycle(1'b1, 32'h0040_0100, 1'b0, 1'b0, 1'b0, 32'h0);
    drive_cycle(1'b1, 32'h0040_0104, 1'b1, 1'b1, 1'b1, 32'h0040_0400);
    checks++;
    if (Mispredict !== 1'b1) begin
      failures++;
      $display("FAIL reset_precond_misp got=%b expected=1", Mispredict);
    end
    RESET = 1'b0;
    #2;  // no clock edge in between
    checks++;
    if ({Branch_resolved, Branch_resolved_addr, Mispredict, Redirect_addr, Resolve_error,
         Branch_count, Mispredict_count, Pred_ready} !== {1'b0, 32'h0, 1'b0, 32'h0, 1'b0,
         32'h0, 32'h0, 1'b1}) begin
      failures++;
      $display("FAIL reset_async got br=%b addr=%h misp=%b redir=%h err=%b bc=%0d mc=%0d rdy=%b expected all 0 rdy=1",
               Branch_resolved, Branch_resolved_addr, Mispredict, Redirect_addr, Resolve_error,
               Branch_count, Mispredict_count, Pred_ready);
    end
    model_reset();
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    drive_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    checks++;
    if (Resolve_error !== 1'b1) begin
      failures++;
      $display("FAIL reset_queue_empty got err=%b expected=1", Resolve_error);
    end
    idle();
  endtask

  task automatic test_correct_predict();
    apply_reset();
    drive_cycle(1'b1, 32'h0040_0100, 1'b1, 1'b0, 1'b0, 32'h0);
    drive_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0040_0200);
    checks++;
    if ({Branch_resolved_addr, Branch_resolved, Mispredict, Branch_count} !==
        {32'h0040_0100, 1'b1, 1'b0, 32'd1}) begin
      failures++;
      $display("FAIL correct_predict got addr=%h br=%b misp=%b bc=%0d expected 00400100 1 0 1",
               Branch_resolved_addr, Branch_resolved, Mispredict, Branch_count);
    end
    idle();
    checks++;
    if ({Branch_resolved_addr, Branch_resolved} !== {32'h0, 1'b0}) begin
      failures++;
      $display("FAIL no_resolve_idle got addr=%h br=%b expected 0 0", Branch_resolved_addr, Branch_resolved);
    end
  endtask

  task automatic test_mispredict_taken();
    apply_reset();
    drive_cycle(1'b1, 32'h0040_0100, 1'b0, 1'b0, 1'b0, 32'h0);
    drive_cycle(1'b1, 32'h0040_0108, 1'b1, 1'b0, 1'b0, 32'h0);
    // Mispredicting resolve with a same-cycle wrong-path enqueue.
    drive_cycle(1'b1, 32'h0040_0500, 1'b1, 1'b1, 1'b1, 32'h0040_0400);
    checks++;
    if ({Mispredict, Redirect_addr, Pred_ready, Mispredict_count} !==
        {1'b1, 32'h0040_0400, 1'b0, 32'd1}) begin
      failures++;
      $display("FAIL mispredict_taken got misp=%b redir=%h rdy=%b mc=%0d expected 1 00400400 0 1",
               Mispredict, Redirect_addr, Pred_ready, Mispredict_count);
    end
    // Resolve during FLUSH is ignored.
    drive_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0);
    checks++;
    if ({Resolve_error, Mispredict, Branch_resolved_addr, Pred_ready, Branch_count} !==
        {1'b0, 1'b0, 32'h0, 1'b1, 32'd1}) begin
      failures++;
      $display("FAIL flush_cycle got err=%b misp=%b addr=%h rdy=%b bc=%0d expected 0 0 0 1 1",
               Resolve_error, Mispredict, Branch_resolved_addr, Pred_ready, Branch_count);
    end
    // Queue must now be empty: neither 0x400108 nor 0x400500 survived.
    drive_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    checks++;
    if ({Resolve_error, Branch_resolved_addr} !== {1'b1, 32'h0}) begin
      failures++;
      $display("FAIL flush_cleared got err=%b addr=%h expected 1 0", Resolve_error, Branch_resolved_addr);
    end
    idle();
  endtask

  task automatic test_mispredict_not_taken();
    apply_reset();
    drive_cycle(1'b1, 32'h0040_0104, 1'b1, 1'b0, 1'b0, 32'h0);
    drive_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    checks++;
    if ({Mispredict, Redirect_addr, Mispredict_count, Branch_resolved, Branch_resolved_addr} !==
        {1'b1, 32'h0040_010C, 32'd1, 1'b0, 32'h0040_0104}) begin
      failures++;
      $display("FAIL mispredict_not_taken got misp=%b redir=%h mc=%0d br=%b addr=%h expected 1 0040010c 1 0 00400104",
               Mispredict, Redirect_addr, Mispredict_count, Branch_resolved, Branch_resolved_addr);
    end
    idle();
    idle();
  endtask

  task automatic test_full();
    logic preds [4];
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      preds[i] = 1'($urandom_range(0, 1));
      drive_cycle(1'b1, 32'h0040_0200 + 32'(i * 4), preds[i], 1'b0, 1'b0, 32'h0);
    end
    checks++;
    if (Pred_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_ready got=%b expected=0", Pred_ready);
    end
    drive_cycle(1'b1, 32'h0040_0300, 1'b0, 1'b0, 1'b0, 32'h0);  // dropped
    // Full: enqueue with resolve in the same cycle is still refused.
    drive_cycle(1'b1, 32'h0040_0304, 1'b0, 1'b1, preds[0], 32'h0040_0800);
    for (int i = 1; i < 4; i++)
      drive_cycle(1'b0, 32'h0, 1'b0, 1'b1, preds[i], 32'h0040_0800);
    checks++;
    if ({Branch_count, Mispredict_count, Branch_resolved_addr} !== {32'd4, 32'd0, 32'h0040_020C}) begin
      failures++;
      $display("FAIL full_drain got bc=%0d mc=%0d addr=%h expected 4 0 0040020c",
               Branch_count, Mispredict_count, Branch_resolved_addr);
    end
    drive_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    checks++;
    if (Resolve_error !== 1'b1) begin
      failures++;
      $display("FAIL full_dropped_entries got err=%b expected=1", Resolve_error);
    end
    // Not full: enqueue and resolve together, occupancy unchanged.
    drive_cycle(1'b1, 32'h0040_0A00, 1'b1, 1'b0, 1'b0, 32'h0);
    drive_cycle(1'b1, 32'h0040_0A04, 1'b0, 1'b1, 1'b1, 32'h0);
    drive_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    checks++;
    if ({Branch_resolved_addr, Mispredict, Branch_count} !== {32'h0040_0A04, 1'b0, 32'd6}) begin
      failures++;
      $display("FAIL enq_and_resolve got addr=%h misp=%b bc=%0d expected 00400a04 0 6",
               Branch_resolved_addr, Mispredict, Branch_count);
    end
    idle();
  endtask

  task automatic test_empty_resolve();
    apply_reset();
    drive_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0040_0000);
    checks++;
    if ({Resolve_error, Branch_resolved_addr, Branch_count, Mispredict_count} !==
        {1'b1, 32'h0, 32'd0, 32'd0}) begin
      failures++;
      $display("FAIL empty_resolve got err=%b addr=%h bc=%0d mc=%0d expected 1 0 0 0",
               Resolve_error, Branch_resolved_addr, Branch_count, Mispredict_count);
    end
    idle();
    checks++;
    if (Resolve_error !== 1'b0) begin
      failures++;
      $display("FAIL error_pulse_width got=%b expected=0", Resolve_error);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int n = 0; n < 120; n++) begin
      drive_cycle(1'($urandom_range(0, 1)),
                  32'h0040_0000 + (32'($urandom_range(1, 255)) << 2),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 1)),
                  32'h0050_0000 + (32'($urandom_range(0, 255)) << 2));
      checks++;
      if ({Pred_ready, Resolve_error, Branch_count, Mispredict_count} !==
          {exp_ready, exp_err, 32'(m_bcount), 32'(m_mcount)}) begin
        failures++;
        $display("FAIL back_to_back cyc=%0d got rdy=%b err=%b bc=%0d mc=%0d expected %b %b %0d %0d",
                 n, Pred_ready, Resolve_error, Branch_count, Mispredict_count,
                 exp_ready, exp_err, m_bcount, m_mcount);
      end
    end
    idle();
    idle();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_correct_predict();
    test_mispredict_taken();
    test_mispredict_not_taken();
    test_full();
    test_empty_resolve();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL final_drain got=%0d pending expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
